// File: rtl/adc_frame_sequencer_if.sv
// ADC handshake, sensor select and frame-buffer write port of the frame sequencer.
// The master modport is the sequencer side.
interface adc_frame_sequencer_if #(
   parameter int ADDR_W = 14
);
   logic [6:0]        row_sel;
   logic [6:0]        col_sel;
   logic              adc_start_n;
   logic              adc_done_n;
   logic [7:0]        adc_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;

   modport master (
      output row_sel, col_sel, adc_start_n, wr_en, wr_addr, wr_data,
      input  adc_done_n, adc_data
   );

   modport slave (
      input  row_sel, col_sel, adc_start_n, wr_en, wr_addr, wr_data,
      output adc_done_n, adc_data
   );
endinterface

// File: rtl/adc_frame_sequencer.sv
// Frame-scan controller: steps row/col select, settles, handshakes with the serial ADC
// driver and writes each sample into the frame buffer at row*COLS+col.
module adc_frame_sequencer #(
   parameter int COLS         = 112,
   parameter int ROWS         = 112,
   parameter int ADDR_W       = 14,
   parameter int SETTLE_TICKS = 4,
   parameter int TIMEOUT      = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  frame_start,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  err,
   adc_frame_sequencer_if.master adcBus
);
   localparam int              SW          = $clog2(SETTLE_TICKS + 1);
   localparam int              TW          = $clog2(TIMEOUT + 1);
   localparam logic [6:0]      LAST_COL    = 7'(COLS - 1);
   localparam logic [6:0]      LAST_ROW    = 7'(ROWS - 1);
   localparam logic [SW-1:0]   SETTLE_LOAD = SW'(SETTLE_TICKS);
   localparam logic [TW-1:0]   TO_LOAD     = TW'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      WAIT_DONE,
      WAIT_ACK,
      ADVANCE,
      DONE
   } state_t;

   state_t            state;
   logic [6:0]        rowSel;
   logic [6:0]        colSel;
   logic              startN;
   logic              wrEn;
   logic [ADDR_W-1:0] wrAddr;
   logic [7:0]        wrData;
   logic [SW-1:0]     settleCnt;
   logic [TW-1:0]     toCnt;

   assign adcBus.row_sel     = rowSel;
   assign adcBus.col_sel     = colSel;
   assign adcBus.adc_start_n = startN;
   assign adcBus.wr_en       = wrEn;
   assign adcBus.wr_addr     = wrAddr;
   assign adcBus.wr_data     = wrData;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         rowSel     <= '0;
         colSel     <= '0;
         startN     <= 1'b1;
         wrEn       <= 1'b0;
         wrAddr     <= '0;
         wrData     <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         err        <= 1'b0;
         settleCnt  <= '0;
         toCnt      <= '0;
      end else begin
         wrEn       <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_start) begin
                  rowSel    <= '0;
                  colSel    <= '0;
                  wrAddr    <= '0;
                  err       <= 1'b0;
                  busy      <= 1'b1;
                  settleCnt <= SETTLE_LOAD;
                  state     <= SETTLE;
               end
            end
            SETTLE: begin
               if (settleCnt == '0) begin
                  startN <= 1'b0;
                  toCnt  <= TO_LOAD;
                  state  <= WAIT_DONE;
               end else begin
                  settleCnt <= settleCnt - SW'(1);
               end
            end
            // Expiry at a count of 1 bounds each handshake wait to exactly TIMEOUT cycles.
            WAIT_DONE: begin
               if (!adcBus.adc_done_n) begin
                  wrData <= adcBus.adc_data;
                  wrEn   <= 1'b1;
                  startN <= 1'b1;
                  toCnt  <= TO_LOAD;
                  state  <= WAIT_ACK;
               end else if (toCnt <= TW'(1)) begin
                  startN <= 1'b1;
                  err    <= 1'b1;
                  state  <= DONE;
               end else begin
                  toCnt <= toCnt - TW'(1);
               end
            end
            WAIT_ACK: begin
               if (adcBus.adc_done_n) begin
                  state <= ADVANCE;
               end else if (toCnt <= TW'(1)) begin
                  err   <= 1'b1;
                  state <= DONE;
               end else begin
                  toCnt <= toCnt - TW'(1);
               end
            end
            ADVANCE: begin
               settleCnt <= SETTLE_LOAD;
               state     <= SETTLE;
               if (colSel < LAST_COL) begin
                  colSel <= colSel + 7'd1;
                  wrAddr <= wrAddr + ADDR_W'(1);
               end else begin
                  colSel <= '0;
                  if (rowSel < LAST_ROW) begin
                     rowSel <= rowSel + 7'd1;
                     wrAddr <= wrAddr + ADDR_W'(1);
                  end else begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               frame_done <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/adc_frame_sequencer.md
# adc_frame_sequencer

Frame-scan controller that sits directly upstream of the 8-bit serial ADC driver in the imager datapath. It steps the sensor row/column select across a full frame. For each pixel it waits a settling interval, then runs the active-low start/complete handshake with the ADC driver. Each returned sample goes out on a single-port write interface into the frame buffer, and completion or fault is reported to the MSS-side control logic.

## Interface
- COLS, 112, pixels per row (≥2)
- ROWS, 112, rows per frame (≥2)
- ADDR_W, 14, frame-buffer address width; COLS*ROWS ≤ 2^ADDR_W
- SETTLE_TICKS, 4, clk cycles between select change and ADC start (≥1)
- TIMEOUT, 64, max clk cycles spent waiting on either handshake edge
- clk  in  1  system clock (20 MHz)
- reset  in  1  asynchronous, active-low reset
- frame_start  in  1  active-high request; sampled only in IDLE
- row_sel  out  7  sensor row select
- col_sel  out  7  sensor column select
- adc_start_n  out  1  start-capture request to ADC driver, active low
- adc_done_n  in  1  conversion-complete from ADC driver, active low
- adc_data  in  8  sample from ADC driver, valid while adc_done_n=0
- wr_en  out  1  one-cycle frame-buffer write strobe
- wr_addr  out  ADDR_W  write address, row*COLS+col
- wr_data  out  8  write data
- busy  out  1  high from frame accept until return to IDLE
- frame_done  out  1  one-cycle pulse at frame end (normal or aborted)
- err  out  1  sticky timeout flag, cleared on next accepted frame_start

## Operation
- Reset values: adc_start_n=1, row_sel=0, col_sel=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, err=0, state IDLE.
- IDLE: frame_start=1 → row/col/wr_addr ← 0, err ← 0, busy ← 1, settle counter ← SETTLE_TICKS, → SETTLE. frame_start is ignored in every other state.
- SETTLE: decrement the counter each cycle. At 0 → adc_start_n ← 0, timeout counter ← TIMEOUT, → WAIT_DONE.
- WAIT_DONE: adc_done_n=0 → wr_data ← adc_data, wr_en ← 1 (one cycle), adc_start_n ← 1, timeout ← TIMEOUT, → WAIT_ACK.
- WAIT_ACK: adc_done_n=1 → ADVANCE.
- ADVANCE, one cycle:
  - col<COLS-1: col++.
  - Otherwise col ← 0; if row<ROWS-1, row++; else → DONE.
  - wr_addr++ on every non-final pixel.
  - Settle counter reloads, → SETTLE.
- DONE: frame_done ← 1 for one cycle, busy ← 0, → IDLE. wr_addr holds the last pixel address (COLS*ROWS-1).
- Timeout: the counter decrements each cycle in WAIT_DONE and WAIT_ACK. On reaching 0 without the expected edge: adc_start_n ← 1, err ← 1, no write, → DONE (frame_done pulses, busy drops).
- The ADC driver's post-conversion quiet time is absorbed by SETTLE plus its own gating. The sequencer never re-asserts adc_start_n before seeing adc_done_n return high.
- Async reset mid-frame: all outputs return to reset values immediately. No partial write strobe is emitted.

## Timing
- Every output is registered. wr_en rises the cycle after adc_done_n=0 is sampled, coincident with adc_start_n rising.
- A select change (ADVANCE edge) is followed by exactly SETTLE_TICKS+1 cycles before adc_start_n falls.
- Per-pixel period = SETTLE_TICKS + 1 (start) + ADC latency + ACK latency + 1 (ADVANCE).
- adc_start_n is held low until adc_done_n=0 is observed, never a pulse.
- Final pixel: the wr_en cycle is followed by WAIT_ACK, then ADVANCE, then frame_done. busy falls together with frame_done.
- frame_start asserted in the same cycle DONE returns to IDLE is not accepted; it must still be high in the IDLE cycle.

## Test plan
- ADC model answering 12 cycles after start, ack 1 cycle; COLS=ROWS=4, frame_start pulse → 16 wr_en strobes, wr_addr 0..15 in order, wr_data matching model samples, a single frame_done, err=0.
- Column wrap: COLS=4 → after col_sel=3/row_sel=0 the next select is col=0/row=1 with wr_addr=4; SETTLE_TICKS=4 → exactly 5 cycles from select change to adc_start_n low.
- Timeout: model never asserts adc_done_n → adc_start_n rises after 64 cycles, err=1, frame_done pulse, no wr_en; next frame_start clears err.
- Stuck ack: adc_done_n held low after the sample → the write occurs once, timeout in WAIT_ACK sets err, and no second start is issued.
- frame_start held high throughout a frame → ignored while busy; a new frame begins on the first IDLE cycle.
- Reset asserted during WAIT_DONE at pixel 5 → adc_start_n=1, busy=0, wr_addr=0 immediately. A following frame_start restarts at pixel 0.
